// File: rtl/event_encoder8to3.sv
// ============================================================================
// Module      : event_encoder8to3
// Description : Captures an 8-bit multi-hot event vector and drains it one
//               set-bit index at a time over a valid/ready output stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module event_encoder8to3 #(
    parameter bit PRIORITY_LSB = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_idx,
    output logic       out_last,
    output logic [3:0] out_count,
    output logic       zero_err
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0] state_q,    state_d;
    logic [7:0] pending_q,  pending_d;
    logic [3:0] count_q,    count_d;
    logic       zero_err_q, zero_err_d;
    logic [2:0] hold_idx_q, hold_idx_d;
    logic       hold_last_q, hold_last_d;

    logic [2:0] sel_idx;
    logic       sel_single;
    logic       in_hs;
    logic       out_hs;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] highest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Presented index and last flag derive only from the registered pending mask.
    generate
        if (PRIORITY_LSB) begin : g_prio_lsb
            assign sel_idx = lowest_set(pending_q);
        end else begin : g_prio_msb
            assign sel_idx = highest_set(pending_q);
        end
    endgenerate

    assign sel_single = (pending_q != 8'd0) && ((pending_q & (pending_q - 8'd1)) == 8'd0);

    assign in_hs  = (state_q == ST_IDLE)  && in_valid;
    assign out_hs = (state_q == ST_DRAIN) && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && (in_vec != 8'd0)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready && sel_single) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DRAIN);
        out_idx   = hold_idx_q;
        out_last  = hold_last_q;
        if (state_q == ST_DRAIN) begin
            out_idx  = sel_idx;
            out_last = sel_single;
        end
    end

    always_comb begin
        pending_d   = pending_q;
        count_d     = count_q;
        zero_err_d  = 1'b0;
        hold_idx_d  = hold_idx_q;
        hold_last_d = hold_last_q;
        if (in_hs) begin
            if (in_vec != 8'd0) begin
                pending_d = in_vec;
                count_d   = popcount8(in_vec);
            end else begin
                zero_err_d = 1'b1;
            end
        end
        // Remember what was last presented so IDLE outputs stay deterministic.
        if (out_hs) begin
            pending_d   = pending_q & ~(8'd1 << sel_idx);
            hold_idx_d  = sel_idx;
            hold_last_d = sel_single;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q   <= 8'd0;
            count_q     <= 4'd0;
            zero_err_q  <= 1'b0;
            hold_idx_q  <= 3'd0;
            hold_last_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            count_q     <= count_d;
            zero_err_q  <= zero_err_d;
            hold_idx_q  <= hold_idx_d;
            hold_last_q <= hold_last_d;
        end
    end

    assign out_count = count_q;
    assign zero_err  = zero_err_q;

endmodule

`default_nettype wire

// File: tb/tb_event_encoder8to3.sv
// ============================================================================
// Module      : tb_event_encoder8to3
// Description : Directed self-checking bench; LSB-first and MSB-first
//               instances share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_event_encoder8to3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       l_in_ready, l_out_valid, l_out_last, l_zero_err;
    logic [2:0] l_out_idx;
    logic [3:0] l_out_count;
    logic       m_in_ready, m_out_valid, m_out_last, m_zero_err;
    logic [2:0] m_out_idx;
    logic [3:0] m_out_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    event_encoder8to3 #(.PRIORITY_LSB(1'b1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_vec(in_vec), .out_valid(l_out_valid), .out_ready(out_ready),
        .out_idx(l_out_idx), .out_last(l_out_last), .out_count(l_out_count),
        .zero_err(l_zero_err)
    );

    event_encoder8to3 #(.PRIORITY_LSB(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_vec(in_vec), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_idx(m_out_idx), .out_last(m_out_last), .out_count(m_out_count),
        .zero_err(m_zero_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full output picture of the LSB instance.
    task automatic check_l(input string tag, input logic rdy, input logic vld,
                           input logic [2:0] idx, input logic last, input logic [3:0] cnt);
        check({tag, ".l_in_ready"},  32'(l_in_ready),  32'(rdy));
        check({tag, ".l_out_valid"}, 32'(l_out_valid), 32'(vld));
        check({tag, ".l_out_idx"},   32'(l_out_idx),   32'(idx));
        check({tag, ".l_out_last"},  32'(l_out_last),  32'(last));
        check({tag, ".l_out_count"}, 32'(l_out_count), 32'(cnt));
    endtask

    task automatic check_m(input string tag, input logic rdy, input logic vld,
                           input logic [2:0] idx, input logic last, input logic [3:0] cnt);
        check({tag, ".m_in_ready"},  32'(m_in_ready),  32'(rdy));
        check({tag, ".m_out_valid"}, 32'(m_out_valid), 32'(vld));
        check({tag, ".m_out_idx"},   32'(m_out_idx),   32'(idx));
        check({tag, ".m_out_last"},  32'(m_out_last),  32'(last));
        check({tag, ".m_out_count"}, 32'(m_out_count), 32'(cnt));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check_l("reset", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
        check_m("reset", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
        check("reset.l_zero_err", 32'(l_zero_err), 32'd0);

        // Two-bit vector, out_ready held high
        in_vec = 8'b0010_0100; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_l("v24.first", 1'b0, 1'b1, 3'd2, 1'b0, 4'd2);
        check_m("v24.first", 1'b0, 1'b1, 3'd5, 1'b0, 4'd2);
        step();
        check_l("v24.second", 1'b0, 1'b1, 3'd5, 1'b1, 4'd2);
        check_m("v24.second", 1'b0, 1'b1, 3'd2, 1'b1, 4'd2);
        step();
        check_l("v24.idle", 1'b1, 1'b0, 3'd5, 1'b1, 4'd2);
        check_m("v24.idle", 1'b1, 1'b0, 3'd2, 1'b1, 4'd2);

        // All-ones vector drains in opposite orders
        in_vec = 8'hFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_l($sformatf("vff.k%0d", k), 1'b0, 1'b1, 3'(k),     (k == 7), 4'd8);
            check_m($sformatf("vff.k%0d", k), 1'b0, 1'b1, 3'(7 - k), (k == 7), 4'd8);
            step();
        end
        check("vff.l_in_ready", 32'(l_in_ready), 32'd1);
        check("vff.m_in_ready", 32'(m_in_ready), 32'd1);

        // Back-pressure holds the single index stable
        in_vec = 8'h80; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_l($sformatf("v80.stall%0d", k), 1'b0, 1'b1, 3'd7, 1'b1, 4'd1);
            check_m($sformatf("v80.stall%0d", k), 1'b0, 1'b1, 3'd7, 1'b1, 4'd1);
            step();
        end
        out_ready = 1'b1;
        check_l("v80.hs", 1'b0, 1'b1, 3'd7, 1'b1, 4'd1);
        step();
        check_l("v80.done", 1'b1, 1'b0, 3'd7, 1'b1, 4'd1);
        check_m("v80.done", 1'b1, 1'b0, 3'd7, 1'b1, 4'd1);

        // Zero vector: one-cycle error pulse, no drain
        in_vec = 8'h00; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("v00.l_zero_err", 32'(l_zero_err), 32'd1);
        check("v00.m_zero_err", 32'(m_zero_err), 32'd1);
        check_l("v00", 1'b1, 1'b0, 3'd7, 1'b1, 4'd1);
        step();
        check("v00.l_zero_err_clr", 32'(l_zero_err), 32'd0);
        check("v00.l_out_valid",    32'(l_out_valid), 32'd0);

        // Reset mid-drain aborts, coinciding with a handshake
        in_vec = 8'h0F; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_l("v0f.h0", 1'b0, 1'b1, 3'd0, 1'b0, 4'd4);
        step();
        check_l("v0f.h1", 1'b0, 1'b1, 3'd1, 1'b0, 4'd4);
        step();
        check_l("v0f.h2", 1'b0, 1'b1, 3'd2, 1'b0, 4'd4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_l("v0f.rst", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
        check_m("v0f.rst", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
        in_vec = 8'h10; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_l("v10", 1'b0, 1'b1, 3'd4, 1'b1, 4'd1);
        check_m("v10", 1'b0, 1'b1, 3'd4, 1'b1, 4'd1);
        step();
        check("v10.l_in_ready", 32'(l_in_ready), 32'd1);

        // Inputs ignored while draining
        in_vec = 8'h03; in_valid = 1'b1;
        step();
        in_vec = 8'hAA; in_valid = 1'b1;
        check_l("vaa.d0", 1'b0, 1'b1, 3'd0, 1'b0, 4'd2);
        check_m("vaa.d0", 1'b0, 1'b1, 3'd1, 1'b0, 4'd2);
        step();
        in_valid = 1'b0;
        check_l("vaa.d1", 1'b0, 1'b1, 3'd1, 1'b1, 4'd2);
        check_m("vaa.d1", 1'b0, 1'b1, 3'd0, 1'b1, 4'd2);
        step();
        check_l("vaa.idle", 1'b1, 1'b0, 3'd1, 1'b1, 4'd2);
        step();
        check("vaa.l_out_valid", 32'(l_out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
